dtls_payload_trim: RTL and testbench
====================================

# dtls_payload_trim

Parametrised DTLS record payload trimmer that sits directly after the DTLS/UDP receive stage in the receive pipeline. It accepts a DTLS record header (record length) plus the record payload stream. It forwards only the first `length - TRIM_BYTES` bytes, with correct `tlast`/`tkeep`. It captures the trailing `TRIM_BYTES` (the AEAD authentication tag) onto a separate handshaked tag port, and flags malformed records.

## Interface
- `DATA_WIDTH`, 64: payload bus width in bits; a multiple of 8, from 8 to 512.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: `tkeep` width.
- `TRIM_BYTES`, 16: number of trailing bytes removed per record; 1 to 32.
- `TAG_ENABLE`, 1: when 1, trimmed bytes are captured and presented on the tag port. When 0, they are discarded, `m_tag_valid` is tied to 0 and state TAG_OUT is never entered.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `s_dtls_hdr_valid` in 1: header valid.
- `s_dtls_hdr_ready` out 1: header accepted.
- `s_dtls_length` in 16: record length in bytes, including the tag.
- `s_axis_tdata` in DATA_WIDTH: record payload data.
- `s_axis_tkeep` in KEEP_WIDTH: record payload byte enables.
- `s_axis_tvalid` in 1: record payload valid.
- `s_axis_tready` out 1: record payload ready.
- `s_axis_tlast` in 1: record payload last beat.
- `s_axis_tuser` in 1: record payload error/user bit.
- `m_axis_tdata` out DATA_WIDTH: trimmed payload data.
- `m_axis_tkeep` out KEEP_WIDTH: trimmed payload byte enables.
- `m_axis_tvalid` out 1: trimmed payload valid.
- `m_axis_tready` in 1: trimmed payload ready.
- `m_axis_tlast` out 1: trimmed payload last beat.
- `m_axis_tuser` out 1: trimmed payload error bit.
- `m_tag_data` out 8*TRIM_BYTES: captured tag; the first tag byte is in bits [7:0].
- `m_tag_valid` out 1: tag valid.
- `m_tag_ready` in 1: tag accepted.
- `busy` out 1: high in any state other than IDLE.
- `error_payload_early_termination` out 1: one-cycle pulse.
- `error_invalid_length` out 1: one-cycle pulse.

## Operation
- Payload byte 0 is byte lane 0 of the first beat. Only the last input beat may have a partial `tkeep`, and that partial `tkeep` is contiguous from lane 0.
- `keep_len = length - TRIM_BYTES`, computed as a 16-bit value.
- `pay_cnt` is a 16-bit count of remaining payload bytes.
- `tag_idx` is a byte index from 0 to TRIM_BYTES-1.
- State machine:
  - **IDLE**: `s_dtls_hdr_ready`=1.
    - Header accepted with `length < TRIM_BYTES`: pulse `error_invalid_length`, go to DROP.
    - Header accepted with `length == TRIM_BYTES`: go to TAG. No payload frame is emitted.
    - Otherwise: load `pay_cnt = keep_len` and go to PAYLOAD.
  - **PAYLOAD**: forward beats; `pay_cnt` decrements by the popcount of accepted `tkeep`.
    - On the beat where `pay_cnt <= KEEP_WIDTH`, the output has `tkeep` = low `pay_cnt` lanes and `tlast`=1.
    - Lanes above `pay_cnt` in that beat are tag bytes and go to capture.
    - Next state is TAG if tag bytes remain, or TAG_OUT/IDLE if the tag is already complete.
    - If input `tlast` arrives before `pay_cnt` is exhausted:
      - output that beat with `tlast`=1 and `tuser`=1;
      - pulse `error_payload_early_termination`;
      - go to IDLE with no tag.
  - **TAG**: consume beats without output; lane bytes are written to `m_tag_data[8*tag_idx +: 8]`.
    - When `tag_idx` reaches TRIM_BYTES with input `tlast`: go to TAG_OUT (or IDLE if TAG_ENABLE=0).
    - When `tag_idx` reaches TRIM_BYTES without input `tlast`: go to DROP.
    - Input `tlast` before the tag is complete: pulse `error_payload_early_termination`, no tag emitted, go to IDLE.
  - **DROP**: `s_axis_tready`=1, discard beats until input `tlast`, then go to TAG_OUT if a complete tag is pending, else IDLE.
  - **TAG_OUT**: `m_tag_valid`=1 until `m_tag_ready`, then go to IDLE. No new header is accepted while a tag is pending.
- `s_axis_tuser`=1 on an input `tlast` beat propagates to `m_axis_tuser` on the output `tlast` beat and suppresses the tag.

## Timing
- The output is registered through a one-entry output register: input beat to `m_axis` latency is 1 cycle.
- In PAYLOAD, `s_axis_tready = m_axis_tready | ~m_axis_tvalid`, which gives full throughput when the sink is always ready.
- In TAG and DROP, `s_axis_tready`=1.
- In IDLE and TAG_OUT, `s_axis_tready`=0.
- `m_tag_valid` rises 1 cycle after the final tag byte is accepted. `m_tag_data` is stable while `m_tag_valid`=1.
- Header accept to first `s_axis_tready`: 1 cycle.
- The error pulses are high for exactly 1 cycle, in the cycle after the causing beat or header is accepted.
- Reset (`rst`=0), effective immediately and asynchronously:
  - state returns to IDLE;
  - all outputs are 0, except `s_dtls_hdr_ready`, which is 1 once reset deasserts;
  - counters and `m_tag_data` are 0.
- Reset mid-record: the partial frame is lost and no `tlast` is emitted.
- Simultaneous `m_tag_ready` and a new `s_dtls_hdr_valid` in TAG_OUT: the header is accepted in the following cycle (IDLE), not in the same cycle.

## Test plan
- **Trim on a beat boundary.** Stimulus: 64-bit, length=40; 5 full input beats of bytes 0..39. Required response: 3 output beats, last `tkeep`=0xFF with `tlast`; `m_tag_data` = bytes 24..39.
- **Partial last beat, tag spanning 3 beats.** Stimulus: length=45; 6 input beats, last `tkeep`=0x1F. Required response: 4 output beats, last `tkeep`=0x1F (29 bytes) with `tlast`; tag = bytes 29..44.
- **Early termination.** Stimulus: length=40, input `tlast` on beat 2 (16 bytes). Required response: beat 2 output with `tlast`=1, `tuser`=1; one `error_payload_early_termination` pulse; `m_tag_valid` never asserted.
- **Invalid and zero-payload lengths.**
  - length=10: one `error_invalid_length` pulse, all beats dropped, no output.
  - length=16: no `m_axis` beats; tag = bytes 0..15.
- **Backpressure.** Stimulus: length=45 with `m_axis_tready` toggled 1/0 every cycle and `m_tag_ready` held 0 for 5 cycles. Required response: identical data to the partial-last-beat case; next header blocked until the tag is accepted.
- **Reset mid-record.** Stimulus: assert `rst`=0 mid-PAYLOAD, release, then send length=40. Required response: all outputs 0 during reset; second record correct, matching the beat-boundary case.

Source files
------------

// File: rtl/dtls_payload_trim_if.sv
// Bundle of the header, payload-in, payload-out, tag and status signals of
// the DTLS payload trimmer. The trimmer uses the slave modport; the
// surrounding pipeline (or a bench) uses the master modport.
interface dtls_payload_trim_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int TRIM_BYTES = 16
);
  logic                    s_dtls_hdr_valid;
  logic                    s_dtls_hdr_ready;
  logic [15:0]             s_dtls_length;
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [KEEP_WIDTH-1:0]   s_axis_tkeep;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic                    s_axis_tuser;
  logic [DATA_WIDTH-1:0]   m_axis_tdata;
  logic [KEEP_WIDTH-1:0]   m_axis_tkeep;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;
  logic                    m_axis_tuser;
  logic [8*TRIM_BYTES-1:0] m_tag_data;
  logic                    m_tag_valid;
  logic                    m_tag_ready;
  logic                    busy;
  logic                    error_payload_early_termination;
  logic                    error_invalid_length;

  modport slave (
    input  s_dtls_hdr_valid, s_dtls_length,
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  m_axis_tready, m_tag_ready,
    output s_dtls_hdr_ready, s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_tag_data, m_tag_valid, busy,
    output error_payload_early_termination, error_invalid_length
  );

  modport master (
    output s_dtls_hdr_valid, s_dtls_length,
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output m_axis_tready, m_tag_ready,
    input  s_dtls_hdr_ready, s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_tag_data, m_tag_valid, busy,
    input  error_payload_early_termination, error_invalid_length
  );
endinterface

// File: rtl/dtls_payload_trim.sv
// DTLS record payload trimmer: forwards the first length-TRIM_BYTES bytes of
// a record, captures the trailing AEAD tag onto a separate handshaked port
// and flags records that are too short or end early.
module dtls_payload_trim #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int TRIM_BYTES = 16,
  parameter int TAG_ENABLE = 1
) (
  input logic                clk,
  input logic                rst,
  dtls_payload_trim_if.slave bus
);
  localparam int          IDXW   = $clog2(TRIM_BYTES + 1);
  localparam logic [15:0] TRIM16 = 16'(TRIM_BYTES);
  localparam logic [15:0] KW16   = 16'(KEEP_WIDTH);

  typedef enum logic [2:0] {IDLE, PAYLOAD, TAG, DROP, TAG_OUT} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             pay_cnt_q, pay_cnt_d;
  logic [IDXW-1:0]         tag_idx_q, tag_idx_d;
  logic                    tag_ok_q, tag_ok_d;   // complete tag waiting for tlast in DROP
  logic [8*TRIM_BYTES-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
  logic                    tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                    err_early_q, err_early_d, err_len_q, err_len_d;

  logic                    hdr_ready, s_ready, hdr_fire, beat, final_pay, cap_en, tag_done;
  logic [15:0]             nb, base, cap_n, idx_sum;
  logic [KEEP_WIDTH-1:0]   low_mask;
  int                      idx;

  // Header is only taken in IDLE, and never while reset is held.
  assign hdr_ready = rst & (state_q == IDLE);
  assign s_ready   = (state_q == PAYLOAD) ? (bus.m_axis_tready | ~tvalid_q)
                                          : (state_q == TAG || state_q == DROP);
  assign hdr_fire  = bus.s_dtls_hdr_valid & hdr_ready;
  assign beat      = bus.s_axis_tvalid & s_ready;
  assign final_pay = pay_cnt_q <= KW16;
  // In the final payload beat the tag starts at lane pay_cnt; in TAG at lane 0.
  assign base      = (state_q == PAYLOAD) ? pay_cnt_q : 16'd0;
  assign cap_en    = beat & (((state_q == PAYLOAD) & final_pay) | (state_q == TAG));
  assign cap_n     = (nb > base) ? (nb - base) : 16'd0;
  assign idx_sum   = 16'(tag_idx_q) + cap_n;
  assign tag_done  = idx_sum >= TRIM16;

  // Popcount of the input keep and the lane mask for the remaining payload bytes.
  always_comb begin
    nb       = '0;
    low_mask = '0;
    for (int l = 0; l < KEEP_WIDTH; l++) begin
      nb          = nb + 16'(bus.s_axis_tkeep[l]);
      low_mask[l] = 16'(l) < pay_cnt_q;
    end
  end

  // Next-state, tag capture, output register and error pulse logic.
  always_comb begin
    state_d     = state_q;
    pay_cnt_d   = pay_cnt_q;
    tag_idx_d   = tag_idx_q;
    tag_ok_d    = tag_ok_q;
    tag_d       = tag_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tvalid_d    = tvalid_q & ~bus.m_axis_tready;
    err_early_d = 1'b0;
    err_len_d   = 1'b0;
    idx         = 0;

    if (cap_en) begin
      tag_idx_d = tag_done ? IDXW'(TRIM_BYTES) : IDXW'(idx_sum);
      if (TAG_ENABLE != 0) begin
        for (int l = 0; l < KEEP_WIDTH; l++) begin
          if (16'(l) >= base && 16'(l) < nb) begin
            idx = int'(tag_idx_q) + l - int'(base);
            if (idx < TRIM_BYTES) tag_d[8*idx +: 8] = bus.s_axis_tdata[8*l +: 8];
          end
        end
      end
    end

    case (state_q)
      IDLE: if (hdr_fire) begin
        tag_idx_d = '0;
        tag_ok_d  = 1'b0;
        if (bus.s_dtls_length < TRIM16) begin
          err_len_d = 1'b1;
          state_d   = DROP;
        end else if (bus.s_dtls_length == TRIM16) begin
          state_d   = TAG;
        end else begin
          pay_cnt_d = bus.s_dtls_length - TRIM16;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: if (beat) begin
        tvalid_d = 1'b1;
        tdata_d  = bus.s_axis_tdata;
        tkeep_d  = bus.s_axis_tkeep;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        if (bus.s_axis_tlast && nb < pay_cnt_q) begin
          // Record shorter than the header claimed: close the frame as errored.
          tlast_d     = 1'b1;
          tuser_d     = 1'b1;
          err_early_d = 1'b1;
          pay_cnt_d   = '0;
          state_d     = IDLE;
        end else if (final_pay) begin
          tkeep_d   = bus.s_axis_tkeep & low_mask;
          tlast_d   = 1'b1;
          tuser_d   = bus.s_axis_tlast & bus.s_axis_tuser;
          pay_cnt_d = '0;
          if (bus.s_axis_tlast) begin
            if (!tag_done) begin
              // Tag truncated: mark the frame errored as well.
              err_early_d = 1'b1;
              tuser_d     = 1'b1;
              state_d     = IDLE;
            end else begin
              state_d = (bus.s_axis_tuser || TAG_ENABLE == 0) ? IDLE : TAG_OUT;
            end
          end else if (tag_done) begin
            tag_ok_d = 1'b1;
            state_d  = DROP;
          end else begin
            state_d  = TAG;
          end
        end else begin
          pay_cnt_d = pay_cnt_q - nb;
        end
      end
      TAG: if (beat) begin
        if (bus.s_axis_tlast) begin
          if (!tag_done) begin
            err_early_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = (bus.s_axis_tuser || TAG_ENABLE == 0) ? IDLE : TAG_OUT;
          end
        end else if (tag_done) begin
          tag_ok_d = 1'b1;
          state_d  = DROP;
        end
      end
      DROP: if (beat && bus.s_axis_tlast) begin
        state_d  = (tag_ok_q && !bus.s_axis_tuser && TAG_ENABLE != 0) ? TAG_OUT : IDLE;
        tag_ok_d = 1'b0;
      end
      TAG_OUT: if (bus.m_tag_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, tag buffer and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pay_cnt_q   <= '0;
      tag_idx_q   <= '0;
      tag_ok_q    <= 1'b0;
      tag_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      err_early_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pay_cnt_q   <= pay_cnt_d;
      tag_idx_q   <= tag_idx_d;
      tag_ok_q    <= tag_ok_d;
      tag_q       <= tag_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      err_early_q <= err_early_d;
      err_len_q   <= err_len_d;
    end
  end

  assign bus.s_dtls_hdr_ready                = hdr_ready;
  assign bus.s_axis_tready                   = s_ready;
  assign bus.m_axis_tdata                    = tdata_q;
  assign bus.m_axis_tkeep                    = tkeep_q;
  assign bus.m_axis_tvalid                   = tvalid_q;
  assign bus.m_axis_tlast                    = tlast_q;
  assign bus.m_axis_tuser                    = tuser_q;
  assign bus.m_tag_data                      = tag_q;
  assign bus.m_tag_valid                     = (TAG_ENABLE != 0) && (state_q == TAG_OUT);
  assign bus.busy                            = state_q != IDLE;
  assign bus.error_payload_early_termination = err_early_q;
  assign bus.error_invalid_length            = err_len_q;
endmodule

// File: tb/tb_dtls_payload_trim.sv
// Scoreboard bench for dtls_payload_trim: directed records, expected beats
// and tags queued at issue time, a negedge monitor pops and compares.
module tb_dtls_payload_trim;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtls_payload_trim_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TRIM_BYTES(TB)) bus();

  dtls_payload_trim #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TRIM_BYTES(TB), .TAG_ENABLE(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  beat_t            exp_q[$];
  logic [8*TB-1:0]  tag_exp_q[$];
  int n_vec = 0, n_err = 0, n_early = 0, n_inv = 0;
  bit bp_mode = 1'b0;

  // Payload byte i carries value i.
  function automatic logic [DW-1:0] pat(input int first);
    logic [DW-1:0] d;
    for (int l = 0; l < KW; l++) d[8*l +: 8] = 8'(first + l);
    return d;
  endfunction

  function automatic logic [DW-1:0] kmask(input logic [KW-1:0] k);
    logic [DW-1:0] m;
    for (int l = 0; l < KW; l++) m[8*l +: 8] = {8{k[l]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake bound expired", name);
  endtask

  task automatic exp_beat(input int first, input logic [KW-1:0] keep, input logic last, input logic user);
    beat_t b;
    b.data = pat(first);
    b.keep = keep;
    b.last = last;
    b.user = user;
    exp_q.push_back(b);
  endtask

  task automatic exp_tag(input int first);
    logic [8*TB-1:0] t;
    for (int j = 0; j < TB; j++) t[8*j +: 8] = 8'(first + j);
    tag_exp_q.push_back(t);
  endtask

  // Monitor: compare every accepted output beat and tag; count error pulses.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data 0x%0h keep 0x%0h, want no beat", bus.m_axis_tdata, bus.m_axis_tkeep);
        end else begin
          e = exp_q.pop_front();
          chk("beat_keep", bus.m_axis_tkeep, e.keep);
          chk("beat_last", bus.m_axis_tlast, e.last);
          chk("beat_user", bus.m_axis_tuser, e.user);
          chk("beat_data", bus.m_axis_tdata & kmask(e.keep), e.data & kmask(e.keep));
        end
      end
      if (bus.m_tag_valid && bus.m_tag_ready) begin
        if (tag_exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_tag: got 0x%0h, want no tag", bus.m_tag_data);
        end else begin
          chk("tag_data", bus.m_tag_data, tag_exp_q.pop_front());
        end
      end
      if (bus.error_payload_early_termination) n_early++;
      if (bus.error_invalid_length) n_inv++;
    end
  end

  // Sink backpressure: toggle tready every cycle while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bp_mode) bus.m_axis_tready = ~bus.m_axis_tready;
    end
  end

  task automatic send_hdr(input logic [15:0] len);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    bus.s_dtls_hdr_valid = 1'b1;
    bus.s_dtls_length    = len;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = bus.s_dtls_hdr_ready;
      @(posedge clk);
      #1;
      t++;
    end
    bus.s_dtls_hdr_valid = 1'b0;
    if (!ok) timeout("hdr_accept");
  endtask

  // Send nbytes of payload (stop early after max_beats beats).
  task automatic send_pay(input int nbytes, input bit user, input int max_beats);
    int sent, b, rem, nk, t;
    bit ok;
    logic [KW-1:0] k;
    sent = 0;
    b = 0;
    while (sent < nbytes && b < max_beats) begin
      rem = nbytes - sent;
      nk  = (rem > KW) ? KW : rem;
      k   = '0;
      for (int l = 0; l < nk; l++) k[l] = 1'b1;
      bus.s_axis_tdata  = pat(sent);
      bus.s_axis_tkeep  = k;
      bus.s_axis_tlast  = (rem <= KW);
      bus.s_axis_tuser  = user && (rem <= KW);
      bus.s_axis_tvalid = 1'b1;
      t = 0;
      ok = 1'b0;
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = bus.s_axis_tready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!ok) timeout("beat_accept");
      sent += nk;
      b++;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || tag_exp_q.size() != 0 || bus.busy || bus.m_axis_tvalid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) timeout("drain");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, bus.m_axis_tvalid, 1'b0);
    chk({tag, "_m_tdata"}, bus.m_axis_tdata, '0);
    chk({tag, "_tag_valid"}, bus.m_tag_valid, 1'b0);
    chk({tag, "_tag_data"}, bus.m_tag_data, '0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_hdr_ready"}, bus.s_dtls_hdr_ready, 1'b0);
    chk({tag, "_s_tready"}, bus.s_axis_tready, 1'b0);
    chk({tag, "_errors"}, {bus.error_payload_early_termination, bus.error_invalid_length}, 2'b00);
  endtask

  task automatic rec40();
    exp_beat(0, 8'hFF, 1'b0, 1'b0);
    exp_beat(8, 8'hFF, 1'b0, 1'b0);
    exp_beat(16, 8'hFF, 1'b1, 1'b0);
    exp_tag(24);
  endtask

  task automatic rec45();
    exp_beat(0, 8'hFF, 1'b0, 1'b0);
    exp_beat(8, 8'hFF, 1'b0, 1'b0);
    exp_beat(16, 8'hFF, 1'b0, 1'b0);
    exp_beat(24, 8'h1F, 1'b1, 1'b0);
    exp_tag(29);
  endtask

  initial begin
    int t;
    bit ok;
    bus.s_dtls_hdr_valid = 1'b0;
    bus.s_dtls_length    = '0;
    bus.s_axis_tdata     = '0;
    bus.s_axis_tkeep     = '0;
    bus.s_axis_tvalid    = 1'b0;
    bus.s_axis_tlast     = 1'b0;
    bus.s_axis_tuser     = 1'b0;
    bus.m_axis_tready    = 1'b1;
    bus.m_tag_ready      = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("hdr_ready_after_reset", bus.s_dtls_hdr_ready, 1'b1);

    // Trim on a beat boundary.
    rec40();
    send_hdr(16'd40);
    send_pay(40, 1'b0, 99);
    drain();

    // Partial last beat, tag across three beats.
    rec45();
    send_hdr(16'd45);
    send_pay(45, 1'b0, 99);
    drain();

    // Early termination: 16 bytes of a 40-byte record.
    exp_beat(0, 8'hFF, 1'b0, 1'b0);
    exp_beat(8, 8'hFF, 1'b1, 1'b1);
    send_hdr(16'd40);
    send_pay(16, 1'b0, 99);
    drain();
    chk("early_pulses", n_early, 1);
    chk("inv_pulses_a", n_inv, 0);

    // Invalid length: everything dropped.
    send_hdr(16'd10);
    send_pay(10, 1'b0, 99);
    drain();
    chk("inv_pulses_b", n_inv, 1);

    // Tag-only record.
    exp_tag(0);
    send_hdr(16'd16);
    send_pay(16, 1'b0, 99);
    drain();

    // tuser on the last input beat suppresses the tag.
    exp_beat(0, 8'hFF, 1'b0, 1'b0);
    exp_beat(8, 8'hFF, 1'b0, 1'b0);
    exp_beat(16, 8'hFF, 1'b1, 1'b0);
    send_hdr(16'd40);
    send_pay(40, 1'b1, 99);
    drain();

    // Backpressure on both output ports; next header blocked by pending tag.
    bp_mode = 1'b1;
    bus.m_tag_ready = 1'b0;
    rec45();
    send_hdr(16'd45);
    send_pay(45, 1'b0, 99);
    t = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = bus.m_tag_valid;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) timeout("tag_valid");
    bus.s_dtls_hdr_valid = 1'b1;
    bus.s_dtls_length    = 16'd40;
    repeat (5) begin
      @(negedge clk);
      chk("hdr_blocked", bus.s_dtls_hdr_ready, 1'b0);
      chk("tag_held", {bus.m_tag_valid, bus.m_tag_data[7:0]}, {1'b1, 8'd29});
      @(posedge clk);
      #1;
    end
    bus.m_tag_ready = 1'b1;
    rec40();
    send_hdr(16'd40);
    send_pay(40, 1'b0, 99);
    bp_mode = 1'b0;
    bus.m_axis_tready = 1'b1;
    drain();

    // Reset in the middle of a record's payload.
    exp_beat(0, 8'hFF, 1'b0, 1'b0);
    send_hdr(16'd40);
    send_pay(40, 1'b0, 2);
    rst = 1'b0;
    #1 chk_reset_outputs("mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("hdr_ready_after_mid_reset", bus.s_dtls_hdr_ready, 1'b1);
    rec40();
    send_hdr(16'd40);
    send_pay(40, 1'b0, 99);
    drain();

    chk("early_pulses_final", n_early, 1);
    chk("inv_pulses_final", n_inv, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("tags_left", tag_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
